alu_req_arbiter: RTL and testbench

Controller that shares the ALU function units (arithmetic, logic, shift, compare) between two command requesters. It round-robin arbitrates requests, sequences a clock-gate wake-up, drives the unit enable and function code, waits for the unit's result flag with a timeout, and returns the captured result to the winning requester. It sits between the system controller / register-file command paths and the ALU units.

---
 rtl/alu_req_arbiter.sv | 118 +++++++++++
 tb/tb_alu_req_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter sharing the ALU units between two requesters,
// sequencing clock-gate wake-up, unit enable, result wait with timeout, and response.
module alu_req_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic              req1_valid_i,
  output logic              req0_ready_o,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [3:0]        req0_fun_i,
  input  logic [3:0]        req1_fun_i,
  output logic              resp0_valid_o,
  output logic              resp1_valid_o,
  output logic [OUT_W-1:0]  resp_data_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [1:0]        alu_fun_o,
  output logic [3:0]        alu_en_o,
  input  logic [OUT_W-1:0]  alu_out_i,
  input  logic              alu_flag_i,
  output logic              gate_en_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAKE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0] fun_q, fun_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic err_q, err_d;
  logic grant, win;
  assign grant = state_q == IDLE && !rst && (req0_valid_i || req1_valid_i);
  assign win = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    fun_d = fun_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = WAKE;
        last_d = win;
        id_d = win;
        a_d = win ? req1_a_i : req0_a_i;
        b_d = win ? req1_b_i : req0_b_i;
        fun_d = win ? req1_fun_i : req0_fun_i;
      end
      WAKE: state_d = ISSUE;
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (alu_flag_i) begin
        data_d = alu_out_i;
        err_d = 1'b0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(TIMEOUT)) begin
          data_d = '0;
          err_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // last_q resets to 1 (req1 "granted last") so req0 is favoured out of reset
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      fun_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      fun_q <= fun_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  assign req0_ready_o = grant && !win;
  assign req1_ready_o = grant && win;
  assign alu_en_o = (state_q == ISSUE || state_q == WAIT) ? 4'b0001 << fun_q[3:2] : 4'b0000;
  assign alu_fun_o = fun_q[1:0];
  assign alu_a_o = a_q;
  assign alu_b_o = b_q;
  assign gate_en_o = state_q != IDLE;
  assign resp0_valid_o = state_q == RESP && !id_q;
  assign resp1_valid_o = state_q == RESP && id_q;
  assign resp_data_o = data_q;
  assign resp_err_o = err_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: vector table, hand sequences and random traffic against a
// transaction-timing reference model of the arbiter, with a latency-programmable ALU unit.
module tb_alu_req_arbiter;
  localparam int T = 4;
  logic clk = 0, rst = 1;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [3:0] req0_fun, req1_fun, alu_en;
  logic resp0_valid, resp1_valid, resp_err, alu_flag, gate_en;
  logic [15:0] resp_data, alu_out;
  logic [1:0] alu_fun;
  int checks = 0, errors = 0;
  int cyc = 0, en_cnt = 0, cur_lat = 1, next_lat = 1;
  bit active = 0, last_id = 1, m_id, m_err;
  int acc_c = 0, resp_c = 0;
  logic [7:0] m_a, m_b;
  logic [3:0] m_fun;
  logic [15:0] m_data;
  int obs_win = -1, resp_at = -1;
  bit resp_seen = 0;
  logic [15:0] seen_data = 0;
  logic seen_err = 0;

  typedef struct {
    int id;
    logic [7:0] a, b;
    logic [3:0] fun;
    int lat, dly;
    logic [15:0] data;
    logic err;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  alu_req_arbiter #(.DATA_W(8), .OUT_W(16), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .req0_fun_i(req0_fun), .req1_fun_i(req1_fun),
    .resp0_valid_o(resp0_valid), .resp1_valid_o(resp1_valid),
    .resp_data_o(resp_data), .resp_err_o(resp_err),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_o(alu_fun), .alu_en_o(alu_en),
    .alu_out_i(alu_out), .alu_flag_i(alu_flag), .gate_en_o(gate_en)
  );

  function automatic logic [15:0] unit_fn(logic [3:0] en, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (en)
      4'b0001: return op == 0 ? 16'(a) + 16'(b) : op == 1 ? 16'(a) - 16'(b) : op == 2 ? 16'(a) * 16'(b) : {a, b};
      4'b0010: return op == 0 ? {8'h0, a & b} : op == 1 ? {8'h0, a | b} : op == 2 ? {8'h0, a ^ b} : {8'h0, ~a};
      4'b0100: return op == 0 ? 16'(a) << b[3:0] : 16'(a) >> b[3:0];
      4'b1000: return op == 0 ? 16'(a < b) : 16'(a == b);
      default: return 16'h0;
    endcase
  endfunction

  // unit model: flag rises cur_lat cycles after its enable first goes high
  assign alu_out = unit_fn(alu_en, alu_fun, alu_a, alu_b);
  assign alu_flag = alu_en != 0 && en_cnt == cur_lat;
  always @(posedge clk) en_cnt <= (alu_en != 0) ? en_cnt + 1 : 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_zero(string nm);
    chk(nm, {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
             alu_a, alu_b, alu_fun, alu_en, gate_en}, 64'h0);
  endtask

  // reference: a command accepted at cycle N owns the ALU until N+3+min(lat,T)
  task automatic check_cycle();
    bit busy, rv;
    int win;
    logic [3:0] en_x;
    obs_win = -1;
    if (rst) begin
      active = 0;
      last_id = 1;
      cyc++;
      return;
    end
    busy = active && cyc <= resp_c;
    win = busy ? -1 : (req0_valid && req1_valid) ? (last_id ? 0 : 1) : req0_valid ? 0 : req1_valid ? 1 : -1;
    chk("ready", {req1_ready, req0_ready}, {win == 1, win == 0});
    obs_win = req0_ready ? 0 : req1_ready ? 1 : -1;
    chk("gate_en", gate_en, busy);
    en_x = (busy && cyc >= acc_c + 2 && cyc < resp_c) ? 4'b0001 << m_fun[3:2] : 4'b0000;
    chk("alu_en", alu_en, en_x);
    if (busy && cyc >= acc_c + 1) chk("alu_operands", {alu_a, alu_b, alu_fun}, {m_a, m_b, m_fun[1:0]});
    rv = busy && cyc == resp_c;
    chk("resp_valid", {resp1_valid, resp0_valid}, {rv && m_id, rv && !m_id});
    if (rv) begin
      chk("resp_data", resp_data, m_data);
      chk("resp_err", resp_err, m_err);
      resp_seen = 1;
      resp_at = cyc - acc_c;
      seen_data = resp_data;
      seen_err = resp_err;
    end
    if (win >= 0) begin
      active = 1;
      acc_c = cyc;
      m_id = win == 1;
      last_id = win == 1;
      m_a = m_id ? req1_a : req0_a;
      m_b = m_id ? req1_b : req0_b;
      m_fun = m_id ? req1_fun : req0_fun;
      cur_lat = next_lat;
      m_err = cur_lat > T;
      resp_c = cyc + 3 + (m_err ? T : cur_lat);
      m_data = m_err ? 16'h0 : unit_fn(4'b0001 << m_fun[3:2], m_fun[1:0], m_a, m_b);
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req0_valid = 0;
    req1_valid = 0;
    for (int k = 0; k < 20 && active && cyc <= resp_c; k++) step();
  endtask

  initial begin
    int n, prev, first_k;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_fun = 0; req1_fun = 0;
    vecs[0] = '{0, 8'hF0, 8'h3C, 4'b0100, 1, 4, 16'h0030, 1'b0};
    vecs[1] = '{1, 8'hAB, 8'hCD, 4'b0011, 3, 6, 16'hABCD, 1'b0};
    vecs[2] = '{0, 8'h55, 8'h66, 4'b1001, 99, 7, 16'h0000, 1'b1};
    vecs[3] = '{1, 8'h12, 8'h34, 4'b0000, 1, 4, 16'h0046, 1'b0};
    vecs[4] = '{0, 8'h05, 8'h07, 4'b0010, 2, 5, 16'h0023, 1'b0};
    vecs[5] = '{1, 8'h81, 8'h03, 4'b1000, 4, 7, 16'h0408, 1'b0};
    vecs[6] = '{0, 8'h10, 8'h20, 4'b1100, 1, 4, 16'h0001, 1'b0};
    vecs[7] = '{1, 8'h01, 8'h01, 4'b0101, 5, 7, 16'h0000, 1'b1};
    @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    step();
    rst = 0;
    // contention from reset: both always valid, req1 payload churns while waiting
    next_lat = 1;
    req0_valid = 1; req1_valid = 1;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_fun = 4'($urandom);
    req1_a = 8'($urandom); req1_fun = 4'($urandom);
    n = 0; prev = 0; first_k = -1;
    for (int k = 0; k < 40 && n < 6; k++) begin
      req1_b = 8'($urandom);
      step();
      if (obs_win >= 0) begin
        chk("rr_order", obs_win, n % 2);
        if (n == 0) first_k = k;
        else chk("rr_spacing", cyc - 1 - prev, 5);
        prev = cyc - 1;
        n++;
        if (obs_win == 0) begin req0_a = 8'($urandom); req0_fun = 4'($urandom); end
        else begin req1_a = 8'($urandom); req1_fun = 4'($urandom); end
      end
    end
    chk("rr_first_cycle", first_k, 0);
    chk("rr_count", n, 6);
    drain();
    foreach (vecs[i]) begin
      next_lat = vecs[i].lat;
      req0_valid = vecs[i].id == 0;
      req1_valid = vecs[i].id == 1;
      req0_a = vecs[i].a; req0_b = vecs[i].b; req0_fun = vecs[i].fun;
      req1_a = vecs[i].a; req1_b = vecs[i].b; req1_fun = vecs[i].fun;
      resp_seen = 0;
      resp_at = -1;
      step();
      chk("vec_grant", obs_win, vecs[i].id);
      req0_valid = 0;
      req1_valid = 0;
      for (int k = 0; k < 12 && !resp_seen; k++) step();
      chk("vec_delay", resp_at, vecs[i].dly);
      chk("vec_data", seen_data, vecs[i].data);
      chk("vec_err", seen_err, vecs[i].err);
    end
    // reset two cycles mid-WAIT with a timeout-bound command from req0
    next_lat = 99;
    req0_valid = 1; req0_a = 8'h9A; req0_b = 8'h3B; req0_fun = 4'b1001;
    step();
    chk("rst_seq_grant", obs_win, 0);
    req0_valid = 0;
    repeat (4) step();
    rst = 1;
    req0_valid = 1;
    step();
    chk_zero("mid_wait_reset_outputs");
    step();
    rst = 0;
    next_lat = 1;
    req1_valid = 1; req1_a = 8'h11; req1_b = 8'h22; req1_fun = 4'b0001;
    req0_a = 8'h44; req0_b = 8'h33; req0_fun = 4'b0000;
    step();
    chk("rst_pointer_favours_req0", obs_win, 0);
    drain();
    for (int k = 0; k < 3000; k++) begin
      if (obs_win == 0 || !req0_valid) begin
        req0_valid = ($urandom % 3) != 0;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_fun = 4'($urandom);
      end else if ($urandom % 4 == 0) req0_b = 8'($urandom);
      if (obs_win == 1 || !req1_valid) begin
        req1_valid = ($urandom % 3) != 0;
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_fun = 4'($urandom);
      end else if ($urandom % 4 == 0) req1_b = 8'($urandom);
      next_lat = $urandom_range(1, 6);
      step();
    end
    drain();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
